// File: rtl/z80_cdc_pkg.sv
// Shared definitions for the clk2-domain write path.
//   state_t    : arbiter FSM encoding {IDLE, CPU_WR, AUX_WR}
//   DATA_WIDTH : width of the data byte carried on every write
package z80_cdc_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_WR = 2'd1,
    AUX_WR = 2'd2
  } state_t;

endpackage

// File: rtl/z80_wr_arbiter_wr_fifo.sv
// Synchronous first-word-fall-through FIFO buffering CPU write ticks.
//   clk, reset : clock and asynchronous active-low reset (pointers only)
//   push, din  : write request and entry; ignored when full unless popping
//   pop        : remove head entry; ignored when empty
//   dout       : head entry, valid whenever empty is low
//   full/empty : occupancy flags
module wr_fifo #(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same edge frees the slot, so a push into a full FIFO is kept.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/z80_wr_arbiter.sv
// Arbitrates one peripheral write bus between buffered CPU write ticks and
// a req/ack AUX requester, round-robin on ties (CPU wins the first tie).
//   clk, reset            : peripheral clock, asynchronous active-low reset
//   cpu_wr_tick/addr/data : one-cycle CPU write, pushed into a FIFO
//   cpu_overrun           : sticky flag, a CPU write was dropped on a full FIFO
//   aux_req/addr/data     : AUX write request, held until aux_ack
//   aux_ack               : one-cycle pulse when the AUX write completes
//   bus_wr/addr/data      : registered write strobe and payload, held until bus_ready
//   bus_ready             : peripheral accepts when bus_wr & bus_ready
//   busy                  : FIFO not empty or a transfer in progress
module z80_wr_arbiter
  import z80_cdc_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_AW    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_wr_tick,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_overrun,
  input  logic                  aux_req,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_data,
  output logic                  aux_ack,
  output logic                  bus_wr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data,
  input  logic                  bus_ready,
  output logic                  busy
);

  localparam int FW = ADDR_WIDTH + DATA_WIDTH;

  state_t        state;
  logic          last_cpu;    // 1: last grant went to CPU, 0: to AUX
  logic [FW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          cpu_pend;
  logic          aux_pend;

  assign fifo_pop = (state == CPU_WR) && bus_ready;

  wr_fifo #(
    .DW(FW),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cpu_wr_tick),
    .pop   (fifo_pop),
    .din   ({cpu_addr, cpu_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cpu_pend = !fifo_empty;
  // While aux_ack is high the requester has not yet had a chance to drop
  // aux_req, so that cycle must not be read as a fresh request.
  assign aux_pend = aux_req && !aux_ack;
  assign busy     = !fifo_empty || (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_cpu    <= 1'b0;
      bus_wr      <= 1'b0;
      bus_addr    <= '0;
      bus_data    <= '0;
      aux_ack     <= 1'b0;
      cpu_overrun <= 1'b0;
    end else begin
      aux_ack <= 1'b0;
      if (cpu_wr_tick && fifo_full && !fifo_pop) cpu_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (cpu_pend && (!aux_pend || !last_cpu)) begin
            state    <= CPU_WR;
            bus_wr   <= 1'b1;
            bus_addr <= fifo_dout[FW-1:DATA_WIDTH];
            bus_data <= fifo_dout[DATA_WIDTH-1:0];
          end else if (aux_pend) begin
            state    <= AUX_WR;
            bus_wr   <= 1'b1;
            bus_addr <= aux_addr;
            bus_data <= aux_data;
          end
        end
        CPU_WR: begin
          if (bus_ready) begin
            state    <= IDLE;
            bus_wr   <= 1'b0;
            last_cpu <= 1'b1;
          end
        end
        AUX_WR: begin
          if (bus_ready) begin
            state    <= IDLE;
            bus_wr   <= 1'b0;
            aux_ack  <= 1'b1;
            last_cpu <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          bus_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule
